// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch with held instruction register and decoded fields.
// Optional IFETCH_REUSE_EN: re-present the held instruction without a memory access while the PC is unchanged.
module ifetch #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rc,
    output logic [4:0]  ra,
    output logic [4:0]  rb,
    output logic [15:0] id,
    output logic        fetch_fault,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t state, state_d;
    logic [31:0] pc_al, mem_addr_d, inst_d, inst_pc_d;
    logic inst_valid_d, fetch_fault_d, drop_pending, drop_pending_d, req_flushed, req_flushed_d;
    logic capture, timeout, reuse_hit;
    logic [CNT_W-1:0] cnt, cnt_d;
    assign pc_al = pc & 32'hFFFF_FFFC;
    assign mem_req = state == REQ;
    assign stall = ~inst_valid;
    assign opcode = inst[31:26];
    assign rc = inst[25:21];
    assign ra = inst[20:16];
    assign rb = inst[15:11];
    assign id = inst[15:0];
    // a response belongs to the live request only if nothing stale is pending and no flush hit it
    assign capture = mem_rvalid && !drop_pending && !flush && !req_flushed &&
                     (state == WAIT || (state == REQ && mem_ack));
    assign timeout = state == WAIT && !mem_rvalid && !flush && cnt == CNT_W'(TIMEOUT - 1);
`ifdef IFETCH_REUSE_EN
    logic reuse_ok;
    always_ff @(posedge clock or posedge reset)
        if (reset) reuse_ok <= 1'b0;
        else reuse_ok <= flush ? 1'b0 : capture ? !mem_err : timeout ? 1'b0 : reuse_ok;
    assign reuse_hit = reuse_ok && pc_al == inst_pc;
`else
    assign reuse_hit = 1'b0;
`endif
    always_comb begin
        state_d = state;
        mem_addr_d = mem_addr;
        inst_d = inst;
        inst_pc_d = inst_pc;
        inst_valid_d = inst_valid;
        fetch_fault_d = fetch_fault;
        drop_pending_d = drop_pending && !mem_rvalid;
        req_flushed_d = req_flushed;
        cnt_d = '0;
        case (state)
            IDLE:
                if (!flush && reuse_hit) begin
                    state_d = HOLD;
                    inst_valid_d = 1'b1;
                end else if (!flush && !drop_pending) begin
                    state_d = REQ;
                    mem_addr_d = pc_al;
                end
            REQ:
                if (mem_ack) begin
                    state_d = (req_flushed || flush) ? IDLE : capture ? HOLD : WAIT;
                    drop_pending_d = (req_flushed || flush) && !mem_rvalid;
                    req_flushed_d = 1'b0;
                end else begin
                    req_flushed_d = req_flushed || flush;
                end
            WAIT:
                if (flush) begin
                    state_d = IDLE;
                    drop_pending_d = !mem_rvalid;
                end else if (capture || timeout) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            HOLD:
                if (flush || advance) state_d = IDLE;
        endcase
        if (capture || timeout) begin
            inst_d = (mem_rvalid && !mem_err) ? mem_rdata : '0;
            inst_pc_d = mem_addr;
            inst_valid_d = 1'b1;
            fetch_fault_d = !mem_rvalid || mem_err;
        end
        if (state == HOLD && advance) begin
            inst_valid_d = 1'b0;
            fetch_fault_d = 1'b0;
        end
        if (timeout) drop_pending_d = 1'b1;
        if (flush) begin
            inst_valid_d = 1'b0;
            fetch_fault_d = 1'b0;
        end
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            mem_addr <= '0;
            inst <= '0;
            inst_pc <= '0;
            inst_valid <= 1'b0;
            fetch_fault <= 1'b0;
            drop_pending <= 1'b0;
            req_flushed <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_d;
            mem_addr <= mem_addr_d;
            inst <= inst_d;
            inst_pc <= inst_pc_d;
            inst_valid <= inst_valid_d;
            fetch_fault <= fetch_fault_d;
            drop_pending <= drop_pending_d;
            req_flushed <= req_flushed_d;
            cnt <= cnt_d;
        end
endmodule
